util_fir_int: RTL and testbench

Two-channel interpolator for the transmit path, the counterpart of the decimating receive filter. It accepts packed `{channel_1, channel_0}` 16-bit sample pairs on an AXI-Stream-style slave and emits INT_FACTOR output pairs per input, using a triangular FIR (linear interpolation) kernel. A bypass mode passes samples through at 1:1. It sits between the baseband sample source and the DAC-rate datapath, all on the 61.44 MHz `aclk` domain.

---
 rtl/util_fir_pkg.sv | 37 +++
 rtl/util_fir_int_lane.sv | 97 +++++++++
 rtl/util_fir_int.sv | 180 ++++++++++++++++++
 tb/tb_util_fir_int.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_fir_pkg.sv
// -----------------------------------------------------------------------------
// util_fir_pkg
// Shared definitions for the util_fir interpolator family:
//   - default sample width and interpolation ratio
//   - clog2 helper used to size the phase counter and the divide-by-ratio shift
//   - handshake FSM state encodings
//   - packed-lane index constants for {channel_1, channel_0} stream words
// -----------------------------------------------------------------------------
package util_fir_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int INT_FACTOR_DEF = 8;

    // Lane positions inside a packed stream word: lane i occupies
    // [i*DATA_WIDTH +: DATA_WIDTH]; with 16-bit samples ch0 = [15:0], ch1 = [31:16].
    localparam int CH0_IDX = 0;
    localparam int CH1_IDX = 1;
    localparam int CH0_LSB = 0;
    localparam int CH1_LSB = 16;

    // EMPTY: nothing pending on the master side. RUN: an output pair is presented.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } fir_state_e;

    // Ceiling log2; for the power-of-two ratios used here it is the exact shift.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = 1; v < value; v = v * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/util_fir_int_lane.sv
// -----------------------------------------------------------------------------
// util_fir_int_lane
// One channel of the interpolator: prev/curr history and the linear
// interpolation y_k = prev + ((curr - prev) * k) >>> SHIFT, plus the
// registered output sample.
//
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   i_clear       : clear history (mode change)
//   i_hist_load   : shift history, prev <= curr, curr <= i_x
//   i_out_load    : input accepted; load output with phase 0 value
//                   (i_x in bypass, old curr in interpolate)
//   i_bypass      : 1 = bypass mode
//   i_step        : advance output to phase i_k
//   i_k           : phase to compute when stepping
//   i_x           : incoming sample for this lane
//   o_y           : registered output sample
// -----------------------------------------------------------------------------
module util_fir_int_lane
    import util_fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SHIFT      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_hist_load,
    input  logic                  i_out_load,
    input  logic                  i_bypass,
    input  logic                  i_step,
    input  logic [SHIFT-1:0]      i_k,
    input  logic [DATA_WIDTH-1:0] i_x,
    output logic [DATA_WIDTH-1:0] o_y
);

    localparam int PW = DATA_WIDTH + 1 + SHIFT;

    logic [DATA_WIDTH-1:0]   r_prev;
    logic [DATA_WIDTH-1:0]   r_curr;
    logic [DATA_WIDTH-1:0]   r_out;

    logic signed [DATA_WIDTH:0] w_diff;
    logic signed [PW-1:0]       w_diff_x;
    logic signed [PW-1:0]       w_k_x;
    logic signed [PW-1:0]       w_prod;
    logic signed [PW-1:0]       w_shifted;
    logic [DATA_WIDTH-1:0]      w_y;
    logic [SHIFT:0]             w_unused_hi;

    // Difference needs one extra bit: full-scale swings span 2^DATA_WIDTH - 1.
    assign w_diff    = $signed({r_curr[DATA_WIDTH-1], r_curr}) - $signed({r_prev[DATA_WIDTH-1], r_prev});
    assign w_diff_x  = {{SHIFT{w_diff[DATA_WIDTH]}}, w_diff};
    // Phase is non-negative, so zero-extend it into the signed product domain.
    assign w_k_x     = {{(DATA_WIDTH + 1){1'b0}}, i_k};
    assign w_prod    = w_diff_x * w_k_x;
    // Arithmetic shift floors toward -inf, so y_k never overshoots prev..curr.
    assign w_shifted = w_prod >>> SHIFT;
    // prev + shifted stays within prev..curr, so the low DATA_WIDTH bits of the
    // sum are exact; the upper shifted bits are pure sign extension.
    assign w_y         = r_prev + w_shifted[DATA_WIDTH-1:0];
    assign w_unused_hi = w_shifted[PW-1:DATA_WIDTH];

    assign o_y = r_out;

    // History registers: cleared on reset or mode change, shifted on input accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= {DATA_WIDTH{1'b0}};
            r_curr <= {DATA_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_prev <= {DATA_WIDTH{1'b0}};
            r_curr <= {DATA_WIDTH{1'b0}};
        end else if (i_hist_load) begin
            r_prev <= r_curr;
            r_curr <= i_x;
        end else begin
            r_prev <= r_prev;
            r_curr <= r_curr;
        end
    end

    // Output sample register: held stable unless a new phase is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= {DATA_WIDTH{1'b0}};
        end else if (i_out_load) begin
            // Phase 0 of a new pair is the old curr, which becomes the new prev.
            r_out <= i_bypass ? i_x : r_curr;
        end else if (i_step) begin
            r_out <= w_y;
        end else begin
            r_out <= r_out;
        end
    end

endmodule

// File: rtl/util_fir_int.sv
// -----------------------------------------------------------------------------
// util_fir_int
// Two-channel linear-interpolation upsampler (INT_FACTOR outputs per input)
// with a 1:1 bypass mode. Owns the stream handshake FSM, the shared phase
// counter and the mode register; per-channel arithmetic lives in
// util_fir_int_lane.
//
// Ports:
//   aclk, reset              : clock, synchronous active-high reset
//   s_axis_data_tvalid/tready: input pair handshake
//   s_axis_data_tdata        : {ch1, ch0} packed input pair
//   interpolate              : 1 = interpolate, 0 = bypass (level)
//   m_axis_data_tvalid/tready: output pair handshake
//   channel_0, channel_1     : registered output samples
// -----------------------------------------------------------------------------
module util_fir_int
    import util_fir_pkg::*;
#(
    parameter int INT_FACTOR = INT_FACTOR_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    s_axis_data_tvalid,
    output logic                    s_axis_data_tready,
    input  logic [2*DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                    interpolate,
    output logic                    m_axis_data_tvalid,
    input  logic                    m_axis_data_tready,
    output logic [DATA_WIDTH-1:0]   channel_0,
    output logic [DATA_WIDTH-1:0]   channel_1
);

    localparam int SHIFT = clog2(INT_FACTOR);
    localparam logic [SHIFT-1:0] LAST_PHASE = SHIFT'(INT_FACTOR - 1);
    localparam logic [SHIFT-1:0] PHASE_ONE  = SHIFT'(1);
    localparam logic [SHIFT-1:0] PHASE_ZERO = SHIFT'(0);

    fir_state_e       r_state;
    fir_state_e       w_state_nxt;
    logic             r_mode;
    logic [SHIFT-1:0] r_phase;

    logic             w_mismatch;
    logic             w_last;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_out_xfer;
    logic             w_mode_upd;
    logic             w_hist_load;
    logic             w_step;
    logic             w_bypass;
    logic [SHIFT-1:0] w_k_next;

    assign w_k_next           = r_phase + PHASE_ONE;
    assign w_bypass           = ~r_mode;
    assign s_axis_data_tready = w_s_ready;
    assign m_axis_data_tvalid = (r_state == ST_RUN);

    // Handshake FSM: input ready, transfers, next state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_accept    = 1'b0;
        w_out_xfer  = 1'b0;
        w_mode_upd  = 1'b0;
        w_hist_load = 1'b0;
        w_step      = 1'b0;
        w_mismatch  = (interpolate != r_mode);
        w_last      = (r_phase == LAST_PHASE);

        // Input is refused while the requested mode differs from the active one,
        // so a mode switch always starts from an empty pipe.
        if (reset) begin
            w_s_ready = 1'b0;
        end else if (w_mismatch) begin
            w_s_ready = 1'b0;
        end else if (!r_mode) begin
            w_s_ready = (r_state == ST_EMPTY) || m_axis_data_tready;
        end else begin
            case (r_state)
                ST_EMPTY: w_s_ready = 1'b1;
                // Reload only as the final phase leaves: no bubble, no overwrite.
                ST_RUN:   w_s_ready = w_last && m_axis_data_tready;
                default:  w_s_ready = 1'b0;
            endcase
        end

        w_accept   = s_axis_data_tvalid && w_s_ready;
        w_out_xfer = (r_state == ST_RUN) && m_axis_data_tready;

        case (r_state)
            ST_EMPTY: begin
                w_mode_upd = w_mismatch;
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else if (w_out_xfer && (!r_mode || w_last)) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase

        w_hist_load = w_accept && r_mode;
        w_step      = w_out_xfer && r_mode && !w_last && !w_accept;
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode register and shared phase counter.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_mode  <= 1'b0;
            r_phase <= PHASE_ZERO;
        end else if (w_mode_upd) begin
            r_mode  <= interpolate;
            r_phase <= PHASE_ZERO;
        end else if (w_hist_load) begin
            r_mode  <= r_mode;
            r_phase <= PHASE_ZERO;
        end else if (w_step) begin
            r_mode  <= r_mode;
            r_phase <= w_k_next;
        end else begin
            r_mode  <= r_mode;
            r_phase <= r_phase;
        end
    end

    util_fir_int_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_lane_ch0 (
        .clk         (aclk),
        .reset       (reset),
        .i_clear     (w_mode_upd),
        .i_hist_load (w_hist_load),
        .i_out_load  (w_accept),
        .i_bypass    (w_bypass),
        .i_step      (w_step),
        .i_k         (w_k_next),
        .i_x         (s_axis_data_tdata[CH0_IDX*DATA_WIDTH +: DATA_WIDTH]),
        .o_y         (channel_0)
    );

    util_fir_int_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_lane_ch1 (
        .clk         (aclk),
        .reset       (reset),
        .i_clear     (w_mode_upd),
        .i_hist_load (w_hist_load),
        .i_out_load  (w_accept),
        .i_bypass    (w_bypass),
        .i_step      (w_step),
        .i_k         (w_k_next),
        .i_x         (s_axis_data_tdata[CH1_IDX*DATA_WIDTH +: DATA_WIDTH]),
        .o_y         (channel_1)
    );

endmodule

// File: tb/tb_util_fir_int.sv
// -----------------------------------------------------------------------------
// tb_util_fir_int
// Self-checking bench for util_fir_int (INT_FACTOR = 8, 16-bit samples).
// A transaction-level model (queue of pending output pairs, integer
// interpolation with floor division) is checked every cycle; directed
// sequences are also pinned against hand-computed literal outputs.
// -----------------------------------------------------------------------------
module tb_util_fir_int;

    localparam int F = 8;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = 32'h0;
    logic        interpolate = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] ch0;
    logic [15:0] ch1;

    int total = 0;
    int bad   = 0;
    bit bp_en = 1'b0;

    // model state
    logic [31:0] exp_q [$];
    logic [15:0] gq0 [$];
    logic [15:0] gq1 [$];
    bit model_mode = 1'b0;
    int mp0 = 0, mc0 = 0, mp1 = 0, mc1 = 0;

    logic [15:0] exp_ramp [8] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300,
                                  16'h0400, 16'h0500, 16'h0600, 16'h0700};
    logic [15:0] exp_neg  [8] = '{16'h0000, 16'hFF00, 16'hFE00, 16'hFD00,
                                  16'hFC00, 16'hFB00, 16'hFA00, 16'hF900};
    logic [15:0] exp_m1   [8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] exp_fs   [8] = '{16'h8000, 16'h9FFF, 16'hBFFF, 16'hDFFF,
                                  16'hFFFF, 16'h1FFF, 16'h3FFF, 16'h5FFF};
    logic [15:0] exp_flat [8] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                  16'h8000, 16'h8000, 16'h8000, 16'h8000};

    util_fir_int #(.INT_FACTOR(F), .DATA_WIDTH(16)) dut (
        .aclk               (aclk),
        .reset              (reset),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .s_axis_data_tdata  (s_tdata),
        .interpolate        (interpolate),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready),
        .channel_0          (ch0),
        .channel_1          (ch1)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // y_k = prev + floor((curr - prev) * k / F)
    function automatic logic [15:0] interp_val(input int p, input int c, input int k);
        int num;
        int q;
        num = (c - p) * k;
        q = num / F;
        if (num < 0 && (num % F) != 0) q = q - 1;
        return 16'(p + q);
    endfunction

    // Downstream ready: constant 1 or random backpressure.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: values are stable at negedge and decide the next edge.
    always @(negedge aclk) begin
        bit pending;
        bit exp_ready;
        if (reset) begin
            chk("ready_in_reset", {31'd0, s_tready}, 32'd0);
            if (exp_q.size() > 0) chk("tvalid_pre_reset", {31'd0, m_tvalid}, 32'd1);
            exp_q.delete();
            model_mode = 1'b0;
            mp0 = 0; mc0 = 0; mp1 = 0; mc1 = 0;
        end else begin
            pending = (exp_q.size() > 0);
            chk("tvalid", {31'd0, m_tvalid}, {31'd0, pending});
            if (pending && m_tvalid) begin
                chk("channel_0", {16'd0, ch0}, {16'd0, exp_q[0][15:0]});
                chk("channel_1", {16'd0, ch1}, {16'd0, exp_q[0][31:16]});
            end
            if (interpolate != model_mode) exp_ready = 1'b0;
            else if (!model_mode) exp_ready = !pending || m_tready;
            else exp_ready = !pending || (exp_q.size() == 1 && m_tready);
            chk("s_tready", {31'd0, s_tready}, {31'd0, exp_ready});
            if (pending && m_tready) begin
                void'(exp_q.pop_front());
                gq0.push_back(ch0);
                gq1.push_back(ch1);
            end
            if (s_tvalid && exp_ready) begin
                if (!model_mode) begin
                    exp_q.push_back(s_tdata);
                end else begin
                    mp0 = mc0; mc0 = int'($signed(s_tdata[15:0]));
                    mp1 = mc1; mc1 = int'($signed(s_tdata[31:16]));
                    for (int k = 0; k < F; k++)
                        exp_q.push_back({interp_val(mp1, mc1, k), interp_val(mp0, mc0, k)});
                end
            end
            if (!pending && interpolate != model_mode) begin
                model_mode = interpolate;
                mp0 = 0; mc0 = 0; mp1 = 0; mc1 = 0;
            end
        end
    end

    task automatic send(input logic [31:0] d);
        bit done;
        done = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            if (s_tready) done = 1'b1;
            @(posedge aclk);
            #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout: data %h never accepted", d);
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge aclk);
            if (!m_tvalid && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: outputs still pending");
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic check_got(input string name, input int ch, input int base, input logic [15:0] exp_v [8]);
        for (int i = 0; i < 8; i++) begin
            if (base + i < gq0.size())
                chk(name, {16'd0, (ch == 0) ? gq0[base + i] : gq1[base + i]}, {16'd0, exp_v[i]});
            else
                chk({name, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_ch0", {16'd0, ch0}, 32'd0);
        chk("rst_ch1", {16'd0, ch1}, 32'd0);
        chk("rst_ready", {31'd0, s_tready}, 32'd0);
        reset = 1'b0;
        @(posedge aclk);
        #1;

        // bypass 1:1
        gq0.delete(); gq1.delete();
        for (int i = 0; i < 10; i++) send(32'h4000_2000);
        idle();
        drain();
        chk("byp_count", gq0.size(), 32'd10);
        for (int i = 0; i < gq0.size(); i++) begin
            chk("byp_ch0", {16'd0, gq0[i]}, 32'h2000);
            chk("byp_ch1", {16'd0, gq1[i]}, 32'h4000);
        end

        // ramp and negative ramp from cleared history
        interpolate = 1'b1;
        gq0.delete(); gq1.delete();
        send(32'hF800_0800);
        send(32'hF800_0800);
        idle();
        drain();
        chk("ramp_count", gq0.size(), 32'd16);
        check_got("ramp_ch0", 0, 0, exp_ramp);
        check_got("neg_ch1", 1, 0, exp_neg);
        for (int i = 8; i < 16 && i < gq0.size(); i++) chk("ramp_hold", {16'd0, gq0[i]}, 32'h0800);

        // floor rounding: 0 then -1
        gq0.delete(); gq1.delete();
        send(32'h0000_0000);
        send(32'h0000_FFFF);
        idle();
        drain();
        check_got("floor_ch0", 0, 8, exp_m1);

        // full scale
        gq0.delete(); gq1.delete();
        send(32'h0000_8000);
        send(32'h0000_8000);
        send(32'h0000_7FFF);
        idle();
        drain();
        check_got("fs_flat", 0, 8, exp_flat);
        check_got("fs_step", 0, 16, exp_fs);

        // random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 6; i++) send($urandom);
        idle();
        repeat (40) @(posedge aclk);
        bp_en = 1'b0;
        #1;
        drain();

        // mode toggle mid-run
        gq0.delete(); gq1.delete();
        send(32'h0000_1000);
        idle();
        repeat (3) @(posedge aclk);
        #1;
        interpolate = 1'b0;
        send(32'h1234_5678);
        idle();
        drain();
        chk("tog_count", gq0.size(), 32'd9);
        if (gq0.size() > 8) begin
            chk("tog_byp_ch0", {16'd0, gq0[8]}, 32'h5678);
            chk("tog_byp_ch1", {16'd0, gq1[8]}, 32'h1234);
        end
        interpolate = 1'b1;
        gq0.delete(); gq1.delete();
        send(32'h0000_0800);
        idle();
        drain();
        check_got("tog_restart", 0, 0, exp_ramp);

        // reset mid-burst at phase 3
        send(32'h0000_0800);
        idle();
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b1;
        @(posedge aclk);
        #1;
        chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("midrst_ch0", {16'd0, ch0}, 32'd0);
        reset = 1'b0;
        gq0.delete(); gq1.delete();
        send(32'h0000_0800);
        idle();
        drain();
        check_got("midrst_ramp", 0, 0, exp_ramp);

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
